coeff_dequantizer: RTL and testbench
====================================

# coeff_dequantizer

Converts 15-bit signed fixed-point LPC coefficients back into IEEE-754 single-precision floats, computing value = -iQuantizedCoeff / 2^SHIFT, which is exactly the inverse of the encoder's fixed-shift quantization. It sits on the verification/analysis side of the hardware encoder and in the decoder datapath. It lets quantized coefficients be compared against, or fed back into, float-domain LPC logic. The block is a fully pipelined, pure-RTL design with no FP IP cores, accepting one coefficient per enabled cycle and carrying the coefficient index alongside.

## Interface
- SHIFT, 10: quantization shift (fractional bits of the input); legal range 0..15.
- iClock  in  1  clock; all logic on posedge.
- iReset  in  1  synchronous, active-high reset; clock iClock.
- iEnable  in  1  pipeline advance; low freezes every pipeline register.
- iValid  in  1  iQuantizedCoeff/iM carry a coefficient this cycle.
- iM  in  4  coefficient index, passed through unchanged.
- iQuantizedCoeff  in  15  signed two's-complement quantized coefficient.
- oFloatCoeff  out  32  IEEE-754 single result.
- oValid  out  1  oFloatCoeff/oM hold a result.
- oM  out  4  index delayed to match oFloatCoeff.

## Operation
- Stage 1 (sign/magnitude):
  - Form the negated value as 16-bit signed (DEQUANTIZER_NEG_EN defined) so that -(-16384) = +16384 is representable.
  - Register the sign and a 15-bit magnitude.
  - Register a zero flag.
- Stage 2 (normalize detect): priority-encode the magnitude to get the leading-one position p (0..14); register p, magnitude, sign, zero.
- Stage 3 (pack):
  - Exponent = 127 + p - SHIFT (8-bit; always in 112..141, so no overflow/denormal).
  - Mantissa = (magnitude << (23 - p))[22:0], with the hidden bit dropped.
  - Register {sign, exponent, mantissa}.
- Conversion is exact; there is no rounding, since magnitude ≤ 2^14 fits in 24 bits.
- Zero input produces 32'h00000000 (+0.0, never -0.0).
- iM and iValid ride a 3-deep shift register in lockstep with the data stages.
- Data registers load every enabled cycle regardless of iValid; oFloatCoeff and oM are meaningful only when oValid=1.

## Timing
- Latency is 3 enabled cycles, from iValid sampled high to the matching oValid high. Throughput is 1 coefficient per enabled cycle, back-to-back.
- iEnable=0: all stage registers, the valid pipe, and the oM pipe hold. Outputs are stable and oValid keeps its value.
- Reset, while iReset=1 at a posedge:
  - Valid pipe is cleared.
  - oValid=0, oFloatCoeff=0, oM=0, and all stage registers are cleared.
  - iReset has priority over iEnable.
- Reset mid-stream discards all in-flight coefficients; none emerge afterwards.
- After reset deasserts, the first oValid appears 3 enabled cycles after the first sampled iValid=1.
- iValid gaps propagate as oValid gaps of identical length; no bubble squeezing.

## Configuration
- DEQUANTIZER_NEG_EN:
  - Defined: output = -iQuantizedCoeff / 2^SHIFT, matching the encoder's negative-scale quantization.
  - Undefined: output = +iQuantizedCoeff / 2^SHIFT. Stage 1 takes the magnitude without the extra negation; the sign is the input sign bit, and -16384 becomes magnitude 16384 with sign 1.
- Latency and interface are identical in both builds.

## Test plan
- NEG_EN defined, SHIFT=10, single iValid pulses:
  - 1024 gives 32'hBF800000.
  - -512 gives 32'h3F000000.
  - 0 gives 32'h00000000.
  - 1 gives 32'hBA800000.
  - Each result appears with oValid exactly 3 cycles after input.
- Extremes with NEG_EN defined: -16384 gives 32'h41800000 (+16.0); 16383 gives 32'hC17FFC00.
- Stream of 8 back-to-back valids, iM=0..7, iEnable high: 8 consecutive oValid cycles with oM=0..7 in order and correct floats.
- iEnable low for 2 cycles mid-stream: outputs and oValid frozen during the stall, stream resumes with no loss or duplication.
- Reset asserted with 2 coefficients in flight: oValid=0 and oFloatCoeff=0 the cycle after, and no stale results emerge once iEnable resumes.
- Build without DEQUANTIZER_NEG_EN: 1024 gives 32'h3F800000; -16384 gives 32'hC1800000.

Source files
------------

// File: rtl/coeff_dequantizer.sv
// Three-stage pipelined fixed-point to IEEE-754 single converter: value = (-)q / 2^SHIFT.
// Define DEQUANTIZER_NEG_EN for the negated (encoder inverse) form; default is +q / 2^SHIFT.
module coeff_dequantizer #(
   parameter int unsigned SHIFT = 10
) (
   input  logic        iClock,
   input  logic        iReset,
   input  logic        iEnable,
   input  logic        iValid,
   input  logic [3:0]  iM,
   input  logic [14:0] iQuantizedCoeff,
   output logic [31:0] oFloatCoeff,
   output logic        oValid,
   output logic [3:0]  oM
);

   logic [15:0] ext_w;
   logic [15:0] signed_w;
   logic        sign_w;
   logic [14:0] mag_w;
   logic        zero_w;

   logic        s1_sign, s1_zero;
   logic [14:0] s1_mag;
   logic        s2_sign, s2_zero;
   logic [14:0] s2_mag;
   logic [3:0]  s2_lead;
   logic [3:0]  lead_w;
   logic [7:0]  exp_w;
   logic [22:0] mant_w;
   logic [31:0] packed_w;

   logic [2:0]  vld_pipe;
   logic [3:0]  m1, m2;

   // 16-bit signed intermediate so -(-16384) stays representable
   always_comb begin
      ext_w = {iQuantizedCoeff[14], iQuantizedCoeff};
`ifdef DEQUANTIZER_NEG_EN
      signed_w = 16'(-ext_w);
`else
      signed_w = ext_w;
`endif
      sign_w = signed_w[15];
      mag_w  = sign_w ? 15'(~signed_w[14:0] + 15'd1) : signed_w[14:0];
      zero_w = (iQuantizedCoeff == '0);
   end

   always_comb begin
      lead_w = '0;
      for (int unsigned i = 0; i < 15; i++) begin
         if (s1_mag[i]) lead_w = 4'(i);
      end
   end

   always_comb begin
      exp_w    = 8'(32'd127 + 32'(s2_lead) - SHIFT);
      mant_w   = 23'({9'd0, s2_mag} << (5'd23 - 5'(s2_lead)));
      packed_w = s2_zero ? '0 : {s2_sign, exp_w, mant_w};
   end

   always_ff @(posedge iClock) begin
      if (iReset) begin
         s1_sign     <= 1'b0;
         s1_zero     <= 1'b0;
         s1_mag      <= '0;
         s2_sign     <= 1'b0;
         s2_zero     <= 1'b0;
         s2_mag      <= '0;
         s2_lead     <= '0;
         oFloatCoeff <= '0;
         vld_pipe    <= '0;
         m1          <= '0;
         m2          <= '0;
         oM          <= '0;
      end else if (iEnable) begin
         s1_sign     <= sign_w;
         s1_zero     <= zero_w;
         s1_mag      <= mag_w;
         s2_sign     <= s1_sign;
         s2_zero     <= s1_zero;
         s2_mag      <= s1_mag;
         s2_lead     <= lead_w;
         oFloatCoeff <= packed_w;
         vld_pipe    <= {vld_pipe[1:0], iValid};
         m1          <= iM;
         m2          <= m1;
         oM          <= m2;
      end
   end

   assign oValid = vld_pipe[2];

endmodule

// File: tb/tb_coeff_dequantizer.sv
// Scoreboard bench for coeff_dequantizer; expectations follow DEQUANTIZER_NEG_EN when defined.
module tb_coeff_dequantizer;

   localparam int unsigned SHIFT = 10;

   logic        iClock, iReset, iEnable, iValid;
   logic [3:0]  iM;
   logic [14:0] iQuantizedCoeff;
   logic [31:0] oFloatCoeff;
   logic        oValid;
   logic [3:0]  oM;

   coeff_dequantizer #(.SHIFT(SHIFT)) dut (
      .iClock(iClock), .iReset(iReset), .iEnable(iEnable), .iValid(iValid),
      .iM(iM), .iQuantizedCoeff(iQuantizedCoeff),
      .oFloatCoeff(oFloatCoeff), .oValid(oValid), .oM(oM)
   );

`ifdef DEQUANTIZER_NEG_EN
   localparam logic [31:0] F_P1024 = 32'hBF800000, F_N512 = 32'h3F000000,
                           F_P1 = 32'hBA800000, F_N16384 = 32'h41800000,
                           F_P16383 = 32'hC17FFC00;
`else
   localparam logic [31:0] F_P1024 = 32'h3F800000, F_N512 = 32'hBF000000,
                           F_P1 = 32'h3A800000, F_N16384 = 32'hC1800000,
                           F_P16383 = 32'h417FFC00;
`endif

   typedef struct {
      logic [31:0] f;
      logic [3:0]  m;
      int unsigned due;
   } exp_t;

   exp_t        sb[$];
   int unsigned en_count = 0;
   int unsigned kind = 3;      // 0 enabled edge, 1 stalled edge, 2 reset edge, 3 none yet
   int unsigned passed = 0;
   int unsigned total = 0;
   logic        snap_v;
   logic [31:0] snap_f;
   logic [3:0]  snap_m;

   initial begin
      iClock = 1'b0;
      forever #5 iClock = ~iClock;
   end

   initial begin
      #100000;
      $display("FAIL timeout: simulation did not finish within bound");
      $fatal(1, "timeout");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
   endtask

   // Exact reference via double precision, repacked as single
   function automatic logic [31:0] model(input logic [14:0] q);
      int          v;
      int          e;
      real         r;
      logic [63:0] d;
      v = int'($signed(q));
`ifdef DEQUANTIZER_NEG_EN
      v = -v;
`endif
      if (v == 0) return '0;
      r = real'(v) / (2.0 ** SHIFT);
      d = $realtobits(r);
      e = int'(d[62:52]) - 1023 + 127;
      return {d[63], e[7:0], d[51:29]};
   endfunction

   always @(posedge iClock) begin
      if (iReset) kind = 2;
      else if (iEnable) begin
         kind = 0;
         en_count = en_count + 1;
      end else kind = 1;
   end

   always @(negedge iClock) begin
      exp_t e;
      case (kind)
         0: begin
            if (oValid) begin
               if (sb.size() == 0) chk("stray_valid", 32'(oValid), 32'd0);
               else begin
                  e = sb.pop_front();
                  chk("float", oFloatCoeff, e.f);
                  chk("index", 32'(oM), 32'(e.m));
                  chk("latency", en_count, e.due);
               end
            end else if (sb.size() != 0 && sb[0].due <= en_count) begin
               chk("missing_valid", 32'(oValid), 32'd1);
               e = sb.pop_front();
            end
         end
         1: begin
            chk("stall_valid", 32'(oValid), 32'(snap_v));
            chk("stall_float", oFloatCoeff, snap_f);
            chk("stall_index", 32'(oM), 32'(snap_m));
         end
         2: begin
            chk("rst_valid", 32'(oValid), 32'd0);
            chk("rst_float", oFloatCoeff, 32'd0);
            chk("rst_index", 32'(oM), 32'd0);
            sb.delete();
         end
         default: ;
      endcase
      snap_v = oValid;
      snap_f = oFloatCoeff;
      snap_m = oM;
   end

   task automatic drive(input logic rst, input logic en, input logic v,
                        input logic [3:0] m, input logic [14:0] q, input logic [31:0] f);
      exp_t e;
      iReset = rst; iEnable = en; iValid = v; iM = m; iQuantizedCoeff = q;
      if (v && en && !rst) begin
         e.f = f; e.m = m; e.due = en_count + 3;
         sb.push_back(e);
      end
      @(posedge iClock);
      #1;
   endtask

   task automatic idle(input int unsigned n);
      for (int unsigned i = 0; i < n; i++) drive(1'b0, 1'b1, 1'b0, 4'd0, 15'd0, 32'd0);
   endtask

   task automatic pulse(input logic [3:0] m, input logic [14:0] q, input logic [31:0] f);
      drive(1'b0, 1'b1, 1'b1, m, q, f);
      idle(4);
   endtask

   initial begin
      logic [14:0] q;
      iReset = 1'b1; iEnable = 1'b1; iValid = 1'b0; iM = '0; iQuantizedCoeff = '0;
      drive(1'b1, 1'b1, 1'b0, 4'd0, 15'd0, 32'd0);
      drive(1'b1, 1'b1, 1'b0, 4'd0, 15'd0, 32'd0);
      idle(2);

      pulse(4'd1, 15'd1024, F_P1024);
      pulse(4'd2, 15'h7E00, F_N512);
      pulse(4'd3, 15'd0, 32'h00000000);
      pulse(4'd4, 15'd1, F_P1);
      pulse(4'd5, 15'h4000, F_N16384);
      pulse(4'd6, 15'h3FFF, F_P16383);

      for (int unsigned i = 0; i < 8; i++) begin
         q = 15'($urandom);
         drive(1'b0, 1'b1, 1'b1, 4'(i), q, model(q));
      end
      idle(5);

      for (int unsigned i = 0; i < 3; i++) begin
         q = 15'($urandom);
         drive(1'b0, 1'b1, 1'b1, 4'(i + 8), q, model(q));
      end
      drive(1'b0, 1'b0, 1'b1, 4'd15, 15'h1234, 32'd0);
      drive(1'b0, 1'b0, 1'b1, 4'd15, 15'h4321, 32'd0);
      for (int unsigned i = 0; i < 3; i++) begin
         q = 15'($urandom);
         drive(1'b0, 1'b1, 1'b1, 4'(i + 11), q, model(q));
      end
      idle(5);

      // Two coefficients in flight, then reset with enable low
      drive(1'b0, 1'b1, 1'b1, 4'd7, 15'd2048, model(15'd2048));
      drive(1'b0, 1'b1, 1'b1, 4'd8, 15'd300, model(15'd300));
      drive(1'b1, 1'b0, 1'b0, 4'd0, 15'd0, 32'd0);
      chk("post_rst_valid", 32'(oValid), 32'd0);
      chk("post_rst_float", oFloatCoeff, 32'd0);
      drive(1'b0, 1'b0, 1'b0, 4'd0, 15'd0, 32'd0);
      drive(1'b0, 1'b0, 1'b0, 4'd0, 15'd0, 32'd0);
      idle(6);

      pulse(4'd9, 15'h7FFF, model(15'h7FFF));
      idle(5);
      chk("sb_empty", 32'(sb.size()), 32'd0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
